// File: rtl/acc_sha256_round_ctrl.sv
// SHA256 round sequencer: accepts one 512-bit block, then drives the message
// scheduler and compression core through LOAD, 64 ROUND cycles, FINAL and DONE.
// Every output except blk_ready is a register loaded from the next state.
module acc_sha256_round_ctrl #(
    parameter int unsigned BLK_W  = 512,
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      soft_clr,
    input  logic                      blk_valid,
    output logic                      blk_ready,
    input  logic [BLK_W-1:0]          blk_data,
    input  logic                      blk_first,
    output logic [BLK_W-1:0]          message,
    output logic                      ms_init,
    output logic                      ms_enable,
    output logic                      comp_init,
    output logic                      comp_first,
    output logic                      comp_enable,
    output logic [$clog2(ROUNDS)-1:0] round_idx,
    output logic                      digest_add,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      busy,
    output logic [CNT_W-1:0]          blk_count
);

    localparam int unsigned RW = $clog2(ROUNDS);
    localparam logic [RW-1:0] LastRound = RW'(ROUNDS - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StRound, StFinal, StDone} state_e;

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   message_q, message_d;
    logic               first_q, first_d;
    logic [RW-1:0]      round_q, round_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ms_init_q, ms_init_d;
    logic               ms_enable_q, ms_enable_d;
    logic               comp_init_q, comp_init_d;
    logic               comp_enable_q, comp_enable_d;
    logic               digest_add_q, digest_add_d;
    logic               res_valid_q, res_valid_d;
    logic               busy_q, busy_d;
    logic               accept;

    // A soft clear in IDLE also suppresses acceptance so the block is not sampled.
    assign blk_ready = (state_q == StIdle);
    assign accept    = blk_ready && blk_valid && !soft_clr;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            message_q     <= '0;
            first_q       <= 1'b0;
            round_q       <= '0;
            count_q       <= '0;
            ms_init_q     <= 1'b0;
            ms_enable_q   <= 1'b0;
            comp_init_q   <= 1'b0;
            comp_enable_q <= 1'b0;
            digest_add_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            message_q     <= message_d;
            first_q       <= first_d;
            round_q       <= round_d;
            count_q       <= count_d;
            ms_init_q     <= ms_init_d;
            ms_enable_q   <= ms_enable_d;
            comp_init_q   <= comp_init_d;
            comp_enable_q <= comp_enable_d;
            digest_add_q  <= digest_add_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state selection; soft_clr overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (blk_valid) state_d = StLoad;
            StLoad:  state_d = StRound;
            StRound: if (round_q == LastRound) state_d = StFinal;
            StFinal: state_d = StDone;
            StDone:  if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (soft_clr) state_d = StIdle;
    end

    // Output values for the cycle after the edge, decoded from the next state.
    always_comb begin
        ms_init_d     = (state_d == StLoad);
        comp_init_d   = (state_d == StLoad);
        ms_enable_d   = (state_d == StRound);
        comp_enable_d = (state_d == StRound);
        digest_add_d  = (state_d == StFinal);
        res_valid_d   = (state_d == StDone);
        busy_d        = (state_d != StIdle);
        message_d     = accept ? blk_data : message_q;
        first_d       = accept ? blk_first : first_q;
        // Counter restarts at 0 on entry to ROUND and is held at 0 elsewhere.
        round_d       = '0;
        if (state_q == StRound && state_d == StRound) round_d = round_q + 1'b1;
        // FINAL is only reachable from the last round, so this counts completed blocks.
        count_d       = (state_d == StFinal) ? count_q + 1'b1 : count_q;
    end

    assign message     = message_q;
    assign comp_first  = first_q;
    assign round_idx   = round_q;
    assign blk_count   = count_q;
    assign ms_init     = ms_init_q;
    assign ms_enable   = ms_enable_q;
    assign comp_init   = comp_init_q;
    assign comp_enable = comp_enable_q;
    assign digest_add  = digest_add_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_acc_sha256_round_ctrl.sv
// Self-checking bench for acc_sha256_round_ctrl: directed timeline scenarios
// plus a randomized run checked against a cycle-count transaction model.
module tb_acc_sha256_round_ctrl;

    localparam int BLK_W = 512;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             soft_clr = 1'b0;
    logic             blk_valid = 1'b0;
    logic             blk_first = 1'b0;
    logic             res_ready = 1'b0;
    logic [BLK_W-1:0] blk_data = '0;
    logic             blk_ready, ms_init, ms_enable, comp_init, comp_first;
    logic             comp_enable, digest_add, res_valid, busy;
    logic [BLK_W-1:0] message;
    logic [5:0]       round_idx;
    logic [CNT_W-1:0] blk_count;

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned exp_count = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    acc_sha256_round_ctrl #(.BLK_W(BLK_W), .ROUNDS(64), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .blk_data(blk_data), .blk_first(blk_first),
        .message(message), .ms_init(ms_init), .ms_enable(ms_enable),
        .comp_init(comp_init), .comp_first(comp_first), .comp_enable(comp_enable),
        .round_idx(round_idx), .digest_add(digest_add), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .blk_count(blk_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BLK_W-1:0] rand_block();
        logic [BLK_W-1:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Packs {blk_ready,busy,ms_init,ms_enable,comp_init,comp_enable,digest_add,res_valid,comp_first}
    function automatic logic [8:0] obs_flags();
        return {blk_ready, busy, ms_init, ms_enable, comp_init, comp_enable,
                digest_add, res_valid, comp_first};
    endfunction

    task automatic run_to_idle();
        int n = 0;
        res_ready = 1'b1;
        while (!(blk_ready && !busy) && n < 200) begin
            tick();
            n++;
        end
        vectors++;
        if (!(blk_ready && !busy)) begin
            miscompares++;
            $display("FAIL run_to_idle: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if (obs_flags() !== 9'b1_0000000_0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required %b", obs_flags(), 9'b100000000);
        end
        vectors++;
        if (round_idx !== 6'd0 || blk_count !== '0) begin
            miscompares++;
            $display("FAIL reset_cnt: round_idx %0d blk_count %0d, required 0 0",
                     round_idx, blk_count);
        end
        vectors++;
        if (message !== '0) begin
            miscompares++;
            $display("FAIL reset_msg: got %h, required 0", message);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if (obs_flags() !== 9'b1_0000000_0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %b, required %b", obs_flags(), 9'b100000000);
        end
        exp_count = 0;
    endtask

    task automatic test_abc_block();
        logic [BLK_W-1:0] abc = '0;
        logic [3:0]       exp_s;
        logic [3:0]       got_s;
        logic [5:0]       exp_idx;
        int               n_en = 0;
        abc[31:0]    = 32'h6162_6380;
        abc[511:480] = 32'h0000_0018;
        blk_data  = abc;
        blk_first = 1'b1;
        res_ready = 1'b1;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        blk_data  = rand_block();
        vectors++;
        if (comp_first !== 1'b1 || message !== abc) begin
            miscompares++;
            $display("FAIL abc_load: comp_first %b msg %h, required 1 %h", comp_first, message, abc);
        end
        for (int c = 1; c <= 67; c++) begin
            if (c > 1) tick();
            exp_s   = {c == 1, c >= 2 && c <= 65, c == 66, c == 67};
            got_s   = {ms_init, ms_enable, digest_add, res_valid};
            exp_idx = (c >= 2 && c <= 65) ? 6'(c - 2) : 6'd0;
            if (ms_enable) n_en++;
            vectors++;
            if (got_s !== exp_s || round_idx !== exp_idx) begin
                miscompares++;
                $display("FAIL abc_c%0d: strobes %b idx %0d, required %b idx %0d",
                         c, got_s, round_idx, exp_s, exp_idx);
            end
        end
        exp_count++;
        vectors++;
        if (n_en != 64 || blk_count !== CNT_W'(exp_count)) begin
            miscompares++;
            $display("FAIL abc_totals: enables %0d count %0d, required 64 %0d",
                     n_en, blk_count, exp_count);
        end
        tick();
        vectors++;
        if (blk_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abc_idle: ready %b busy %b, required 1 0", blk_ready, busy);
        end
    endtask

    task automatic test_res_stall();
        logic [BLK_W-1:0] a = rand_block();
        logic [BLK_W-1:0] b = rand_block();
        blk_data  = a;
        blk_first = 1'b0;
        res_ready = 1'b0;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        repeat (66) tick();
        exp_count++;
        blk_data  = b;
        blk_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            vectors++;
            if ({res_valid, blk_ready, ms_init} !== 3'b100 || message !== a
                || blk_count !== CNT_W'(exp_count)) begin
                miscompares++;
                $display("FAIL stall_%0d: valid/ready/init %b cnt %0d, required 100 %0d",
                         i, {res_valid, blk_ready, ms_init}, blk_count, exp_count);
            end
            if (i < 10) tick();
        end
        res_ready = 1'b1;
        tick();
        vectors++;
        if ({res_valid, blk_ready, busy, ms_init} !== 4'b0100 || message !== a) begin
            miscompares++;
            $display("FAIL stall_release: valid/ready/busy/init %b, required 0100",
                     {res_valid, blk_ready, busy, ms_init});
        end
        tick();
        blk_valid = 1'b0;
        vectors++;
        if (ms_init !== 1'b1 || message !== b) begin
            miscompares++;
            $display("FAIL stall_next_load: ms_init %b msg %h, required 1 %h", ms_init, message, b);
        end
        run_to_idle();
        exp_count++;
    endtask

    task automatic test_back_to_back();
        int   r1 = -1;
        int   r2 = -1;
        int   loads = 0;
        logic f1 = 1'bx;
        logic f2 = 1'bx;
        res_ready = 1'b1;
        blk_first = 1'b1;
        blk_data  = rand_block();
        blk_valid = 1'b1;
        for (int c = 0; c < 200 && r2 < 0; c++) begin
            tick();
            if (ms_init) begin
                loads++;
                if (loads == 1) begin
                    f1 = comp_first;
                    blk_first = 1'b0;
                    blk_data = rand_block();
                end else begin
                    f2 = comp_first;
                    blk_valid = 1'b0;
                end
            end
            if (res_valid) begin
                if (r1 < 0) r1 = cyc;
                else r2 = cyc;
            end
        end
        exp_count += 2;
        vectors++;
        if (loads != 2 || f1 !== 1'b1 || f2 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: loads %0d comp_first %b,%b, required 2 1,0", loads, f1, f2);
        end
        vectors++;
        if (r2 - r1 != 68) begin
            miscompares++;
            $display("FAIL b2b_period: got %0d, required 68", r2 - r1);
        end
        vectors++;
        if (blk_count !== CNT_W'(exp_count)) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d, required %0d", blk_count, exp_count);
        end
        tick();
    endtask

    task automatic test_soft_clr();
        logic [BLK_W-1:0] a = rand_block();
        int rc = -1;
        blk_data  = a;
        blk_first = 1'b1;
        res_ready = 1'b1;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        repeat (31) tick();
        vectors++;
        if (round_idx !== 6'd30) begin
            miscompares++;
            $display("FAIL sclr_pre: round_idx %0d, required 30", round_idx);
        end
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
        vectors++;
        if (obs_flags() !== 9'b1_0000000_1 || round_idx !== 6'd0) begin
            miscompares++;
            $display("FAIL sclr_idle: flags %b idx %0d, required 100000001 0", obs_flags(), round_idx);
        end
        vectors++;
        if (blk_count !== CNT_W'(exp_count) || message !== a) begin
            miscompares++;
            $display("FAIL sclr_keep: count %0d, required %0d (message retained)",
                     blk_count, exp_count);
        end
        blk_data  = rand_block();
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            if (c > 1) tick();
            if (res_valid && rc < 0) rc = c;
        end
        exp_count++;
        vectors++;
        if (rc != 67 || blk_count !== CNT_W'(exp_count)) begin
            miscompares++;
            $display("FAIL sclr_after: res_valid at c%0d count %0d, required c67 %0d",
                     rc, blk_count, exp_count);
        end
    endtask

    task automatic test_async_reset();
        blk_data  = rand_block();
        blk_first = 1'b1;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        repeat (11) tick();
        vectors++;
        if (round_idx !== 6'd10) begin
            miscompares++;
            $display("FAIL arst_pre: round_idx %0d, required 10", round_idx);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs_flags() !== 9'b1_0000000_0 || round_idx !== 6'd0) begin
            miscompares++;
            $display("FAIL arst_flags: flags %b idx %0d, required 100000000 0", obs_flags(), round_idx);
        end
        vectors++;
        if (blk_count !== '0 || message !== '0) begin
            miscompares++;
            $display("FAIL arst_regs: count %0d, required 0 (message cleared)", blk_count);
        end
        exp_count = 0;
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (blk_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_release: ready %b busy %b, required 1 0", blk_ready, busy);
        end
    endtask

    // Model: k = cycles since acceptance (0 idle, 1 load, 2..65 rounds, 66 final, 67 done).
    task automatic test_random();
        int               k = 0;
        int               blocks = 0;
        int               n = 0;
        logic [BLK_W-1:0] m_msg = '0;
        logic             m_first = 1'b0;
        logic [8:0]       exp_f;
        logic [5:0]       exp_idx;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        exp_count = 0;
        while (blocks < 200 && n < 40000) begin
            blk_valid = ($urandom_range(0, 3) != 0);
            blk_first = 1'($urandom);
            blk_data  = rand_block();
            res_ready = ($urandom_range(0, 2) != 0);
            soft_clr  = ($urandom_range(0, 399) == 0);
            if (soft_clr) k = 0;
            else if (k == 0) begin
                if (blk_valid) begin
                    k = 1;
                    m_msg = blk_data;
                    m_first = blk_first;
                end
            end else if (k < 67) begin
                k++;
                if (k == 66) exp_count++;
            end else if (res_ready) begin
                k = 0;
                blocks++;
            end
            tick();
            n++;
            exp_f = {k == 0, k != 0, k == 1, k >= 2 && k <= 65, k == 1, k >= 2 && k <= 65,
                     k == 66, k == 67, m_first};
            exp_idx = (k >= 2 && k <= 65) ? 6'(k - 2) : 6'd0;
            vectors++;
            if (obs_flags() !== exp_f || round_idx !== exp_idx) begin
                miscompares++;
                $display("FAIL rand_cyc%0d: flags %b idx %0d, required %b idx %0d",
                         n, obs_flags(), round_idx, exp_f, exp_idx);
            end
            vectors++;
            if (message !== m_msg || blk_count !== CNT_W'(exp_count)) begin
                miscompares++;
                $display("FAIL rand_data%0d: count %0d, required %0d (or message differs)",
                         n, blk_count, exp_count);
            end
            vectors++;
            if ((ms_init && ms_enable) || ($countones({comp_init, comp_enable, digest_add}) > 1)) begin
                miscompares++;
                $display("FAIL rand_excl%0d: init/en %b%b comp %b, required exclusive",
                         n, ms_init, ms_enable, {comp_init, comp_enable, digest_add});
            end
        end
        soft_clr = 1'b0;
        vectors++;
        if (blocks < 200) begin
            miscompares++;
            $display("FAIL rand_budget: %0d blocks, required 200", blocks);
        end
    endtask

    initial begin
        test_reset();
        test_abc_block();
        test_res_stall();
        test_back_to_back();
        test_soft_clr();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
